// File: rtl/dmem_dual_lane_arbiter_if.sv
// Bundle of the two load/store lane handshakes plus the data-memory port.
// The slave modport is the arbiter; the master modport is everything around
// it (the two MEM-stage lanes and the memory itself).
interface dmem_dual_lane_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    // Lane 0 (always the older instruction)
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp0_err;

    // Lane 1 (always the younger instruction)
    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              rsp1_err;

    // Single-port data memory
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_dual_lane_arbiter.sv
// Shares one single-port data memory between the two load/store lanes.
// Lane 0 carries the older instruction, so it wins ties; a lane-1 request
// that loses is parked in PEND1 and served next cycle ahead of anything new
// on lane 0, which keeps program order and makes older stores visible to
// younger loads. Responses are registered, one cycle after the grant.
// Optional feature: define DMEM_STALL_CNT_EN to add a saturating 16-bit
// stall counter output (stall_cnt).
module dmem_dual_lane_arbiter #(
    parameter int MEM_WORDS = 64,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    dmem_dual_lane_arbiter_if.slave bus
`ifdef DMEM_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        PEND1 = 1'b1
    } state_t;

    localparam logic [ADDR_W-3:0] WORD_LIMIT = (ADDR_W-2)'(MEM_WORDS);

    state_t            state_q, state_d;
    logic              grant0, grant1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;

    logic              rsp0_valid_q, rsp1_valid_q;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp1_rdata_q;
    logic              rsp0_err_q, rsp1_err_q;

    // Arbitration: pick at most one lane per cycle and decide the next state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        grant0  = 1'b0;
        grant1  = 1'b0;
        state_d = IDLE;
        if (state_q == PEND1 && bus.req1_valid) begin
            // Parked lane-1 request goes first, even over a new lane-0 one.
            grant1 = 1'b1;
        end else if (bus.req0_valid) begin
            grant0 = 1'b1;
            if (bus.req1_valid) begin
                state_d = PEND1;
            end
        end else if (bus.req1_valid) begin
            grant1 = 1'b1;
        end
    end

    // Memory-side mux: route the granted lane, drive zeros when idle.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (grant0) begin
            sel_we    = bus.req0_we;
            sel_addr  = bus.req0_addr;
            sel_wdata = bus.req0_wdata;
        end else if (grant1) begin
            sel_we    = bus.req1_we;
            sel_addr  = bus.req1_addr;
            sel_wdata = bus.req1_wdata;
        end
    end

    // Word-aligned range check; the two byte-offset bits are ignored.
    assign in_range = (sel_addr[ADDR_W-1:2] < WORD_LIMIT);

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.mem_we     = (grant0 || grant1) && sel_we && in_range;
    assign bus.mem_addr   = sel_addr;
    assign bus.mem_wdata  = sel_wdata;

    // State register; reset drops any parked lane-1 request.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered per-lane responses, valid for exactly one cycle after grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp0_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp0_err_q   <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_rdata_q <= '0;
            rsp1_err_q   <= 1'b0;
        end else begin
            rsp0_valid_q <= grant0;
            rsp1_valid_q <= grant1;
            if (grant0) begin
                rsp0_rdata_q <= (!sel_we && in_range) ? bus.mem_rdata : '0;
                rsp0_err_q   <= !in_range;
            end
            if (grant1) begin
                rsp1_rdata_q <= (!sel_we && in_range) ? bus.mem_rdata : '0;
                rsp1_err_q   <= !in_range;
            end
        end
    end

    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp0_rdata = rsp0_rdata_q;
    assign bus.rsp0_err   = rsp0_err_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp1_rdata = rsp1_rdata_q;
    assign bus.rsp1_err   = rsp1_err_q;

`ifdef DMEM_STALL_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [16:0] stall_sum;

    assign stall_sum = {1'b0, stall_cnt_q}
                     + 17'(bus.req0_valid && !grant0)
                     + 17'(bus.req1_valid && !grant1);

    // Saturating count of lane-cycles spent waiting for a grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_sum[16] ? 16'hFFFF : stall_sum[15:0];
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/dmem_dual_lane_arbiter.md
Name: dmem_dual_lane_arbiter

Overview:
- Shares the single-port data memory (64 x 32-bit words, write on posedge when WE, combinational word-aligned read) between the two load/store lanes of the superscalar core.
- Lane 0 always carries the older instruction. Arbitration therefore preserves program order, and an older store is always visible to a younger load.
- Sits between the two MEM-stage lanes and the data memory.
- Returns a registered response per lane and back-pressures the losing lane.

Parameters:
- MEM_WORDS, 64: number of 32-bit words in the data memory; bounds the legal address range.
- DATA_W, 32: data width.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  lane-0 request
- req0_we  in  1  lane-0 write (1) / read (0)
- req0_addr  in  ADDR_W  lane-0 byte address
- req0_wdata  in  DATA_W  lane-0 store data
- req0_ready  out  1  lane-0 grant, combinational
- rsp0_valid  out  1  lane-0 response valid, registered
- rsp0_rdata  out  DATA_W  lane-0 load data
- rsp0_err  out  1  lane-0 out-of-range flag
- req1_*, rsp1_*  same set for lane 1
- mem_we  out  1  data memory WE
- mem_addr  out  ADDR_W  data memory A
- mem_wdata  out  DATA_W  data memory WD
- mem_rdata  in  DATA_W  data memory RD

Behaviour:
- Handshake
  - A request transfers on a cycle where valid && ready.
  - A requester holds valid, we, addr and wdata stable until ready.
  - Deasserting valid before grant (flush) is the only legal exception.
- State machine: IDLE, PEND1.
  - IDLE, only req0_valid: grant lane 0; stay in IDLE.
  - IDLE, only req1_valid: grant lane 1; stay in IDLE.
  - IDLE, both valid: grant lane 0; go to PEND1.
  - PEND1, req1_valid=1: grant lane 1 unconditionally, even if lane 0 has a new (younger) request; go to IDLE.
  - PEND1, req1_valid=0 (flushed): behave as IDLE this cycle, including the both-valid case.
- Memory drive
  - mem_addr and mem_wdata = granted lane's addr and wdata. With no grant, drive 0.
  - mem_we = granted && we && in_range.
- Range check
  - in_range = (addr[ADDR_W-1:2] < MEM_WORDS).
  - addr[1:0] is ignored (word aligned).
- Response
  - On the grant edge, the granted lane's rsp_valid <= 1 for exactly one cycle.
  - Read, in range: rdata <= mem_rdata.
  - Write, or out of range: rdata <= 0.
  - rsp_err <= !in_range. An out-of-range write is suppressed.
  - Latency: response valid 1 cycle after grant.
  - A non-granted lane's rsp_valid is 0.
- Ordering
  - A lane-0 store granted at edge N updates the memory at edge N.
  - A lane-1 load granted in the following cycle therefore returns the new data (RAW safe).
- Reset (asynchronous, any time)
  - state = IDLE.
  - All rsp_valid, rsp_rdata and rsp_err = 0.
  - Any pending lane-1 request is dropped; the requester must re-present it.
  - Combinational outputs follow their inputs as soon as reset releases.
- At most one memory access per cycle; no buffering beyond the PEND1 state.

Optional Feature:
- Macro: DMEM_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt[15:0].
  - Increments once per cycle for each lane with valid && !ready, so +2 if both lanes stall.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: the port and the counter logic are absent. Arbitration behaviour is identical either way.

Test Plan:
- Single lane-0 read:
  - Stimulus: preload word 1 = 32'h1FD961AB; req0 read addr 0x4.
  - Required: req0_ready=1 the same cycle; next cycle rsp0_valid=1, rsp0_rdata=32'h1FD961AB, rsp0_err=0.
- Simultaneous requests:
  - Stimulus: cycle N, req0 read 0x0 and req1 read 0x4.
  - Required: lane 0 granted in N, lane 1 granted in N+1; rsp0 = 32'h11111111 at N+1; rsp1 = 32'h1FD961AB at N+2; stall_cnt = 1 if enabled.
- Same-address RAW:
  - Stimulus: lane-0 write 0x8 = 32'hDEADBEEF and lane-1 read 0x8 in the same cycle.
  - Required: rsp1_rdata = 32'hDEADBEEF.
- PEND1 priority:
  - Stimulus: lane 1 is pending in PEND1 while lane 0 presents a new write to 0xC.
  - Required: lane 1 is served first; the lane-0 write lands one cycle later.
- Out of range:
  - Stimulus: req1 write addr 0x100 (word 64).
  - Required: mem_we=0; rsp1_err=1; rsp1_rdata=0; memory unchanged.
- Reset in PEND1:
  - Stimulus: assert reset mid-cycle while in PEND1.
  - Required: immediately rsp*_valid=0 and state IDLE. After release, lane 1 re-presents and is granted in IDLE.
